// File: rtl/adder_tree_sched_if.sv
// Handshake bundle for adder_tree_sched: serial operand stream in, burst sum out.
// The slave modport is the sequencer side; the master modport is the producer/consumer side.
interface adder_tree_sched_if #(
  parameter int W  = 7,
  parameter int CW = 8
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          in_last;
  logic          in_ci;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  out_s;
  logic [CW-1:0] out_cnt;
  logic          busy;

  modport slave (
    input  in_valid, in_data, in_last, in_ci, out_ready,
    output in_ready, out_valid, out_s, out_cnt, busy
  );

  modport master (
    output in_valid, in_data, in_last, in_ci, out_ready,
    input  in_ready, out_valid, out_s, out_cnt, busy
  );
endinterface

// File: rtl/adder_tree_sched.sv
// Buffers a serial operand burst into the 10 lanes of a 7-bit carry-save adder tree,
// running extra passes (partial sum fed back into lane 0) for bursts longer than 10.
module adder_tree_sched #(
  parameter int W     = 7,
  parameter int LANES = 10,
  parameter int CW    = 8
) (
  input  logic               clk,
  input  logic               rst,
  adder_tree_sched_if.slave  bus
);
  localparam int IW = $clog2(LANES);
  localparam logic [IW-1:0] LAST_IDX = IW'(LANES - 1);

  typedef enum logic [1:0] {IDLE, FILL, LAUNCH, OUT} state_t;

  state_t                      state_q, state_d;
  logic [LANES-1:0][W-1:0]     lane_q, lane_d;
  logic [IW-1:0]               idx_q, idx_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        ci_q, ci_d;
  logic                        first_q, first_d;
  logic                        last_q, last_d;
  logic [W-1:0]                out_s_q, out_s_d;
  logic [CW-1:0]               out_cnt_q, out_cnt_d;
  logic                        in_ready_c;
  logic                        accept;
  logic [W-1:0]                tree_s;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + 1'b1;
  endfunction

  // Carry-save reduction of all lanes, resolved by one final add; the
  // carry out of the top bit is dropped, so the result is modulo 2^W.
  function automatic logic [W-1:0] tree_sum(input logic [LANES-1:0][W-1:0] ops,
                                            input logic ci);
    logic [W-1:0] ps, pc, ns;
    ps = '0;
    pc = '0;
    for (int i = 0; i < LANES; i++) begin
      ns = ps ^ pc ^ ops[i];
      pc = ((ps & pc) | (ps & ops[i]) | (pc & ops[i])) << 1;
      ps = ns;
    end
    return ps + pc + W'(ci);
  endfunction

  assign tree_s = tree_sum(lane_q, first_q & ci_q);
  assign accept = bus.in_valid & in_ready_c;

  always_comb begin
    state_d    = state_q;
    lane_d     = lane_q;
    idx_d      = idx_q;
    cnt_d      = cnt_q;
    ci_d       = ci_q;
    first_d    = first_q;
    last_d     = last_q;
    out_s_d    = out_s_q;
    out_cnt_d  = out_cnt_q;
    in_ready_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready_c = 1'b1;
        if (accept) begin
          lane_d    = '0;
          lane_d[0] = bus.in_data;
          ci_d      = bus.in_ci;
          idx_d     = IW'(1);
          cnt_d     = CW'(1);
          first_d   = 1'b1;
          last_d    = bus.in_last;
          state_d   = bus.in_last ? LAUNCH : FILL;
        end
      end
      FILL: begin
        in_ready_c = 1'b1;
        if (accept) begin
          lane_d[idx_q] = bus.in_data;
          idx_d         = idx_q + IW'(1);
          cnt_d         = sat_inc(cnt_q);
          last_d        = bus.in_last;
          if (bus.in_last || idx_q == LAST_IDX) state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        lane_d = '0;
        if (last_q) begin
          out_s_d   = tree_s;
          out_cnt_d = cnt_q;
          state_d   = OUT;
        end else begin
          // Partial sum occupies lane 0, so the next pass takes 9 new operands.
          lane_d[0] = tree_s;
          idx_d     = IW'(1);
          first_d   = 1'b0;
          state_d   = FILL;
        end
      end
      OUT: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      lane_q    <= '0;
      idx_q     <= '0;
      cnt_q     <= '0;
      ci_q      <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
      out_s_q   <= '0;
      out_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      lane_q    <= lane_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      ci_q      <= ci_d;
      first_q   <= first_d;
      last_q    <= last_d;
      out_s_q   <= out_s_d;
      out_cnt_q <= out_cnt_d;
    end
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = (state_q == OUT);
  assign bus.out_s     = out_s_q;
  assign bus.out_cnt   = out_cnt_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_adder_tree_sched.sv
// Directed bench for adder_tree_sched: single-operand, one-pass, multi-pass,
// output back-pressure and mid-burst reset cases with hand-computed results.
module tb_adder_tree_sched;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   launch_cycles = 0;
  logic stalled;

  always #5 clk = ~clk;

  adder_tree_sched_if #(.W(7), .CW(8)) bus ();

  adder_tree_sched #(.W(7), .LANES(10), .CW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // A launch cycle is the only busy state with neither in_ready nor out_valid.
  always @(negedge clk)
    if (!rst && bus.busy && !bus.in_ready && !bus.out_valid) launch_cycles++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [6:0] d, input logic last, input logic ci);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    bus.in_ci    = ci;
    while (!bus.in_ready && waited < 50) begin
      stalled = 1'b1;
      tick();
      waited++;
    end
    if (waited >= 50) check("send_timeout", 32'(waited), 32'd0);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_ci    = 1'b0;
  endtask

  task automatic wait_out();
    int waited;
    waited = 0;
    while (!bus.out_valid && waited < 50) begin
      tick();
      waited++;
    end
    if (waited >= 50) check("out_timeout", 32'(waited), 32'd0);
  endtask

  task automatic take_out();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  initial begin
    int l0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.in_ci     = 1'b0;
    bus.out_ready = 1'b0;
    stalled       = 1'b0;

    // Reset state
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    check("rst_in_ready",  bus.in_ready,  1);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_s",     bus.out_s,     0);
    check("rst_out_cnt",   bus.out_cnt,   0);
    check("rst_busy",      bus.busy,      0);

    // Single operand 5 with carry-in
    send(7'd5, 1'b1, 1'b1);
    check("t1_launch_valid", bus.out_valid, 0);
    check("t1_launch_busy",  bus.busy,      1);
    tick();
    check("t1_out_valid", bus.out_valid, 1);
    check("t1_out_s",     bus.out_s,     6);
    check("t1_out_cnt",   bus.out_cnt,   1);
    take_out();
    check("t1_done_valid", bus.out_valid, 0);
    check("t1_done_busy",  bus.busy,      0);
    check("t1_hold_s",     bus.out_s,     6);

    // Ten operands 1..10, one pass
    stalled = 1'b0;
    for (int i = 1; i <= 10; i++) send(7'(i), (i == 10), 1'b0);
    check("t2_no_stall", stalled, 0);
    check("t2_launch_ready", bus.in_ready, 0);
    wait_out();
    check("t2_out_s",   bus.out_s,   55);
    check("t2_out_cnt", bus.out_cnt, 10);
    take_out();

    // Twelve operands of 20 with carry-in, two passes
    for (int i = 1; i <= 10; i++) send(7'd20, 1'b0, 1'b1);
    check("t3_pass_ready_lo", bus.in_ready, 0);
    tick();
    check("t3_pass_ready_hi", bus.in_ready, 1);
    send(7'd20, 1'b0, 1'b1);
    send(7'd20, 1'b1, 1'b1);
    wait_out();
    check("t3_out_s",   bus.out_s,   113);
    check("t3_out_cnt", bus.out_cnt, 12);
    take_out();

    // Nineteen ones: exactly two launches
    l0 = launch_cycles;
    for (int i = 1; i <= 19; i++) send(7'd1, (i == 19), 1'b0);
    wait_out();
    check("t4_launches", 32'(launch_cycles - l0), 2);
    check("t4_out_s",    bus.out_s,   19);
    check("t4_out_cnt",  bus.out_cnt, 19);
    take_out();

    // Output back-pressure
    send(7'd7, 1'b0, 1'b0);
    send(7'd8, 1'b1, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      check("t5_hold_valid", bus.out_valid, 1);
      check("t5_hold_s",     bus.out_s,     15);
      check("t5_hold_ready", bus.in_ready,  0);
      tick();
    end
    take_out();
    check("t5_rel_ready", bus.in_ready,  1);
    check("t5_rel_valid", bus.out_valid, 0);
    check("t5_cnt",       bus.out_cnt,   2);

    // Mid-burst reset discards buffered operands
    for (int i = 0; i < 4; i++) send(7'd50, 1'b0, 1'b1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_rst_in_ready",  bus.in_ready,  1);
    check("t6_rst_out_valid", bus.out_valid, 0);
    check("t6_rst_out_s",     bus.out_s,     0);
    check("t6_rst_out_cnt",   bus.out_cnt,   0);
    check("t6_rst_busy",      bus.busy,      0);
    send(7'd3, 1'b0, 1'b0);
    send(7'd4, 1'b1, 1'b0);
    wait_out();
    check("t6_out_s",   bus.out_s,   7);
    check("t6_out_cnt", bus.out_cnt, 2);
    take_out();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/adder_tree_sched.md
Name: adder_tree_sched

Overview:
Sequencer that feeds the 10-operand, 7-bit carry-save adder tree from a serial operand stream. It accepts one operand per cycle over a valid/ready handshake and buffers operands into the tree's 10 input lanes. Bursts longer than 10 operands run as multiple passes, with the partial sum fed back into lane 0 of the next pass. The final 7-bit sum is presented over a valid/ready output handshake. The tree is instantiated inside this block and is used combinationally.

Parameters:
W, 7, operand/sum width; fixed at 7 by the tree, any other value is illegal.
LANES, 10, tree input lanes; fixed at 10.
CW, 8, width of the operand counter.

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  operand present
in_ready  output  1  block can accept operand this cycle
in_data  input  7  operand
in_last  input  1  operand is final of burst; qualified by in_valid&in_ready
in_ci  input  1  carry-in for burst; sampled with first operand of burst only
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_s  output  7  burst sum modulo 128
out_cnt  output  CW  operands in burst, saturating at 2^CW-1
busy  output  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE; lanes, acc, idx, cnt, ci_reg cleared.
  - Reset values: in_ready=1, out_valid=0, out_s=0, out_cnt=0, busy=0.
  - Reset mid-burst discards all buffered operands; no output is produced for that burst.
- Accept = in_valid & in_ready.
- States: IDLE, FILL, LAUNCH, OUT.
- IDLE:
  - in_ready=1.
  - On accept: lane[0]=in_data, ci_reg=in_ci, idx=1, cnt=1, first=1.
  - If in_last, go to LAUNCH; else go to FILL.
- FILL:
  - in_ready=1.
  - On accept: lane[idx]=in_data, idx+1, cnt+1 (saturating).
  - Go to LAUNCH if in_last, or if idx was 9 (lane 9 written); otherwise stay in FILL.
  - No accept leaves state unchanged.
- LAUNCH (exactly 1 cycle):
  - in_ready=0.
  - Tree inputs: the 10 lanes, with unwritten lanes driven to 0. Tree ci = ci_reg if first, else 0.
  - acc <= tree s; tree co is ignored. All lanes are cleared.
  - If the burst ended: go to OUT, with out_s=acc and out_cnt=cnt.
  - Else: lane[0]=tree s, idx=1, first=0, go to FILL.
- OUT:
  - out_valid=1, in_ready=0, out_s and out_cnt held stable.
  - On out_valid & out_ready: go to IDLE, out_valid=0 next cycle. out_s and out_cnt keep their last values until the next result.
- Latency:
  - Last operand accepted at cycle t gives LAUNCH at t+1 and out_valid=1 at t+2.
  - Intermediate pass: the 10th operand accepted at t gives in_ready=0 at t+1 and in_ready=1 at t+2.
- Arithmetic: out_s = (sum of all operands + ci) mod 128. There is no overflow indication.
- Throughput: a new burst is accepted no earlier than the cycle after the OUT handshake; no overlap with OUT.
- in_ci on non-first operands is ignored. in_last is meaningful only on accept.
- Pass boundary: after an intermediate launch, lane 0 holds the partial sum, so each subsequent pass takes 9 new operands.
  - A burst of exactly 10 operands completes in one pass.
  - A burst of exactly 19 completes in two passes.

Test Plan:
- Reset, then single operand 5, in_ci=1, in_last=1 -> out_valid 2 cycles later, out_s=6, out_cnt=1; busy falls after out_ready.
- Operands 1..10 back-to-back, in_ci=0, in_last on 10th -> out_s=55, out_cnt=10; in_ready never drops before LAUNCH.
- 12 operands of 20, in_ci=1 -> in_ready=0 exactly one cycle after 10th accept; out_s=(240+1) mod 128=113, out_cnt=12.
- 19 operands of 1, in_ci=0 -> two LAUNCH cycles; out_s=19, out_cnt=19.
- Burst 7,8 with out_ready held low 5 cycles -> out_valid=1, out_s=15 stable, in_ready=0 throughout; one cycle after out_ready=1, in_ready=1 and out_valid=0.
- Assert rst after 4 operands accepted -> next cycle all outputs at reset values; then burst 3,4 with in_ci=0 -> out_s=7, out_cnt=2 (no residue from aborted burst).
